// File: rtl/monitor_interface.sv
// monitor_interface
//
// Video output stage at the end of the palette path. Generates raster timing
// (horizontal/vertical counters, blank, sync) and turns the 16-bit colour word
// from the colour RAM into 8-bit RGB. Each 4-bit colour field is scaled by
// (intensity + 1). A two-stage pixel pipeline delays RGB and sync by two pixel
// enables relative to the raw raster position.
//
// Ports
//   clk      system clock, all state updates on the rising edge
//   reset    synchronous, active-high reset
//   MCKF     pixel enable, one clk pulse per pixel
//   D        colour word: [15:12] I, [11:8] R, [7:4] G, [3:0] B
//   HPOS     raw horizontal count
//   VPOS     raw vertical count
//   HBLANK   raw horizontal blank (HPOS >= H_VISIBLE)
//   VBLANK   raw vertical blank (VPOS >= V_VISIBLE)
//   HSYNC_b  active-low horizontal sync, pipeline aligned with RGB
//   VSYNC_b  active-low vertical sync, pipeline aligned with RGB
//   FRAME    one-clk pulse when the raster wraps to 0,0
//   RED, GREEN, BLUE  8-bit colour outputs, zero while blanked

module monitor_interface #(
    parameter int H_TOTAL   = 456,
    parameter int H_VISIBLE = 336,
    parameter int HS_START  = 368,
    parameter int HS_WIDTH  = 32,
    parameter int V_TOTAL   = 262,
    parameter int V_VISIBLE = 240,
    parameter int VS_START  = 243,
    parameter int VS_WIDTH  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MCKF,
    input  logic [15:0] D,
    output logic [8:0]  HPOS,
    output logic [8:0]  VPOS,
    output logic        HBLANK,
    output logic        VBLANK,
    output logic        HSYNC_b,
    output logic        VSYNC_b,
    output logic        FRAME,
    output logic [7:0]  RED,
    output logic [7:0]  GREEN,
    output logic [7:0]  BLUE
);

    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_VIS    = 9'(H_VISIBLE);
    localparam logic [8:0] V_VIS    = 9'(V_VISIBLE);
    localparam logic [8:0] HS_FIRST = 9'(HS_START);
    localparam logic [8:0] HS_LAST  = 9'(HS_START + HS_WIDTH - 1);
    localparam logic [8:0] VS_FIRST = 9'(VS_START);
    localparam logic [8:0] VS_LAST  = 9'(VS_START + VS_WIDTH - 1);

    logic [8:0]  h_count;
    logic [8:0]  v_count;
    logic        line_end;
    logic        frame_end;
    logic        hs_window;
    logic        vs_window;

    // Stage 1 registers: the word and timing flags of the pixel being presented.
    logic [15:0] word_q;
    logic        blank_q;
    logic        hs_q;
    logic        vs_q;

    // Scale one 4-bit colour field by (intensity + 1); 15 * 16 = 240 fits in 8 bits.
    function automatic logic [7:0] scale(input logic [3:0] c, input logic [3:0] i);
        return {4'b0000, c} * ({4'b0000, i} + 8'd1);
    endfunction

    assign line_end  = (h_count == H_LAST);
    assign frame_end = line_end && (v_count == V_LAST);
    assign hs_window = (h_count >= HS_FIRST) && (h_count <= HS_LAST);
    assign vs_window = (v_count >= VS_FIRST) && (v_count <= VS_LAST);

    assign HPOS   = h_count;
    assign VPOS   = v_count;
    assign HBLANK = (h_count >= H_VIS);
    assign VBLANK = (v_count >= V_VIS);

    // Raster counters and frame strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state is always written with <= so every register
            // samples the pre-edge values of the others, independent of order.
            h_count <= '0;
            v_count <= '0;
            FRAME   <= 1'b0;
        end else begin
            // Cleared on every clk without a wrapping enable, so the pulse is one clk wide.
            FRAME <= MCKF && frame_end;
            if (MCKF) begin
                if (line_end) begin
                    h_count <= '0;
                    v_count <= frame_end ? 9'd0 : v_count + 9'd1;
                end else begin
                    h_count <= h_count + 9'd1;
                end
            end
        end
    end

    // Two-stage pixel pipeline. Sync travels through the same two stages as
    // colour so both arrive at the monitor together.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q  <= '0;
            blank_q <= 1'b1;   // first pixels after reset come out black
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            RED     <= '0;
            GREEN   <= '0;
            BLUE    <= '0;
            HSYNC_b <= 1'b1;
            VSYNC_b <= 1'b1;
        end else if (MCKF) begin
            word_q  <= D;
            blank_q <= HBLANK | VBLANK;
            hs_q    <= hs_window;
            vs_q    <= vs_window;
            RED     <= blank_q ? 8'h00 : scale(word_q[11:8], word_q[15:12]);
            GREEN   <= blank_q ? 8'h00 : scale(word_q[7:4],  word_q[15:12]);
            BLUE    <= blank_q ? 8'h00 : scale(word_q[3:0],  word_q[15:12]);
            HSYNC_b <= ~hs_q;
            VSYNC_b <= ~vs_q;
        end
    end

endmodule

// File: tb/tb_monitor_interface.sv
// tb_monitor_interface
//
// Drives two instances from shared inputs: one with the default raster
// geometry and one with a small geometry so that whole frames, vertical sync
// and frame wrap are exercised in a short run. Outputs are compared against a
// reference model that derives everything from the number of enables since
// reset and a history of the colour words presented.

module tb_monitor_interface;

    typedef struct packed {
        int ht; int hv; int hs; int hw;
        int vt; int vv; int vs; int vw;
    } geom_t;

    localparam geom_t GA = '{ht: 456, hv: 336, hs: 368, hw: 32,
                             vt: 262, vv: 240, vs: 243, vw: 3};
    localparam geom_t GB = '{ht: 20, hv: 12, hs: 14, hw: 3,
                             vt: 10, vv: 7, vs: 8, vw: 1};

    typedef struct {
        logic [15:0] d;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        MCKF;
    logic [15:0] D;

    logic [8:0] a_hpos, a_vpos, b_hpos, b_vpos;
    logic       a_hblank, a_vblank, a_hsync_b, a_vsync_b, a_frame;
    logic       b_hblank, b_vblank, b_hsync_b, b_vsync_b, b_frame;
    logic [7:0] a_red, a_green, a_blue, b_red, b_green, b_blue;
    logic [46:0] obs_a, obs_b;

    int checks = 0;
    int errors = 0;
    logic [15:0] d_hist[$];   // colour word presented at each enable since reset

    always #5 clk = ~clk;

    monitor_interface dut_a (
        .clk(clk), .reset(reset), .MCKF(MCKF), .D(D),
        .HPOS(a_hpos), .VPOS(a_vpos), .HBLANK(a_hblank), .VBLANK(a_vblank),
        .HSYNC_b(a_hsync_b), .VSYNC_b(a_vsync_b), .FRAME(a_frame),
        .RED(a_red), .GREEN(a_green), .BLUE(a_blue)
    );

    monitor_interface #(
        .H_TOTAL(20), .H_VISIBLE(12), .HS_START(14), .HS_WIDTH(3),
        .V_TOTAL(10), .V_VISIBLE(7), .VS_START(8), .VS_WIDTH(1)
    ) dut_b (
        .clk(clk), .reset(reset), .MCKF(MCKF), .D(D),
        .HPOS(b_hpos), .VPOS(b_vpos), .HBLANK(b_hblank), .VBLANK(b_vblank),
        .HSYNC_b(b_hsync_b), .VSYNC_b(b_vsync_b), .FRAME(b_frame),
        .RED(b_red), .GREEN(b_green), .BLUE(b_blue)
    );

    assign obs_a = {a_hpos, a_vpos, a_hblank, a_vblank, a_hsync_b, a_vsync_b, a_frame,
                    a_red, a_green, a_blue};
    assign obs_b = {b_hpos, b_vpos, b_hblank, b_vblank, b_hsync_b, b_vsync_b, b_frame,
                    b_red, b_green, b_blue};

    // Expected outputs after n enables. The raw position is n modulo the raster;
    // RGB and sync after enable n describe the pixel presented at enable n-1,
    // whose position was n-2 enables into the raster.
    function automatic logic [46:0] model(input geom_t g, input int n, input bit fresh);
        int ft;
        int h, v, p, ph, pv, i;
        logic [15:0] w;
        logic [7:0] r, gr, b;
        logic hs, vs, fr;
        ft = g.ht * g.vt;
        h  = n % g.ht;
        v  = (n / g.ht) % g.vt;
        r = 8'h00; gr = 8'h00; b = 8'h00;
        hs = 1'b1; vs = 1'b1;
        if (n >= 2) begin
            p  = (n - 2) % ft;
            ph = p % g.ht;
            pv = p / g.ht;
            w  = d_hist[n - 2];
            i  = int'(w[15:12]) + 1;
            if (ph < g.hv && pv < g.vv) begin
                r  = 8'(int'(w[11:8]) * i);
                gr = 8'(int'(w[7:4]) * i);
                b  = 8'(int'(w[3:0]) * i);
            end
            hs = !(ph >= g.hs && ph < g.hs + g.hw);
            vs = !(pv >= g.vs && pv < g.vs + g.vw);
        end
        fr = fresh && n > 0 && (n % ft) == 0;
        return {9'(h), 9'(v), 1'(h >= g.hv), 1'(v >= g.vv), hs, vs, fr, r, gr, b};
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h (enables=%0d)", name, actual, expected,
                     d_hist.size());
        end
    endtask

    task automatic check_both(input string tag, input bit fresh);
        check({tag, "_a"}, 64'(obs_a), 64'(model(GA, d_hist.size(), fresh)));
        check({tag, "_b"}, 64'(obs_b), 64'(model(GB, d_hist.size(), fresh)));
    endtask

    // One enable with word d, followed by gap idle clocks checked for hold.
    // Entered and left #1 after a rising edge.
    task automatic pulse(input logic [15:0] d, input int gap);
        MCKF = 1'b1;
        D    = d;
        @(posedge clk);
        d_hist.push_back(d);
        #1;
        MCKF = 1'b0;
        check_both("enable", 1'b1);
        for (int k = 0; k < gap; k++) begin
            @(posedge clk);
            #1;
            check_both("hold", 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int bright, dark, hs_low, vs_low, frames, last_frame, n0;

        vecs[0] = '{d: 16'hFF80, r: 8'hF0, g: 8'h80, b: 8'h00};
        vecs[1] = '{d: 16'h0111, r: 8'h01, g: 8'h01, b: 8'h01};
        vecs[2] = '{d: 16'h7A53, r: 8'h50, g: 8'h28, b: 8'h18};
        vecs[3] = '{d: 16'hFFFF, r: 8'hF0, g: 8'hF0, b: 8'hF0};
        vecs[4] = '{d: 16'h8421, r: 8'h24, g: 8'h12, b: 8'h09};
        vecs[5] = '{d: 16'h3C0F, r: 8'h30, g: 8'h00, b: 8'h3C};

        // Reset held three clocks with the pixel enable toggling.
        reset = 1'b1;
        MCKF  = 1'b0;
        D     = 16'h0000;
        repeat (3) begin
            @(posedge clk);
            #1;
            MCKF = ~MCKF;
        end
        check("reset_hpos", 64'(a_hpos), 64'd0);
        check("reset_vpos", 64'(a_vpos), 64'd0);
        check("reset_rgb", 64'({a_red, a_green, a_blue}), 64'd0);
        check("reset_sync", 64'({a_hsync_b, a_vsync_b}), 64'b11);
        check("reset_frame", 64'(a_frame), 64'd0);
        reset = 1'b0;
        MCKF  = 1'b0;
        d_hist.delete();
        check_both("released", 1'b0);

        // Intensity scaling vectors in the visible area; each word held two enables.
        for (int i = 0; i < 6; i++) begin
            pulse(vecs[i].d, 0);
            if (i == 0) check("first_enable_black", 64'({a_red, a_green, a_blue}), 64'd0);
            pulse(vecs[i].d, 0);
            check("vec_rgb", 64'({a_red, a_green, a_blue}),
                  64'({vecs[i].r, vecs[i].g, vecs[i].b}));
        end

        // White held for a whole line: visible/blank split and hsync width.
        bright = 0; dark = 0; hs_low = 0;
        for (int i = 0; i < 458; i++) begin
            pulse(16'hFFFF, 0);
            if (i >= 2) begin
                if (a_red == 8'hF0) bright++;
                else if (a_red == 8'h00) dark++;
                if (!a_hsync_b) hs_low++;
            end
        end
        check("line_bright_enables", 64'(bright), 64'd336);
        check("line_dark_enables", 64'(dark), 64'd120);
        check("hsync_low_enables", 64'(hs_low), 64'd32);

        // Dense random run covering several small-raster frames.
        frames = 0; last_frame = -1; vs_low = 0;
        for (int i = 0; i < 1200; i++) begin
            pulse(16'($urandom()), 0);
            if (i < 200 && !b_vsync_b) vs_low++;
            if (b_frame) begin
                if (last_frame >= 0) check("frame_gap", 64'(d_hist.size() - last_frame), 64'd200);
                last_frame = d_hist.size();
                frames++;
            end
        end
        check("frame_count", 64'(frames), 64'd6);
        check("vsync_low_enables", 64'(vs_low), 64'd20);

        // Sparse enables: one every third clk, outputs held in between.
        for (int i = 0; i < 600; i++) pulse(16'($urandom()), 2);

        // Dense run up to HPOS=100, VPOS=50, then reset with MCKF high.
        n0 = 50 * 456 + 100;
        while (d_hist.size() < n0) pulse(16'($urandom()), 0);
        check("pre_reset_hpos", 64'(a_hpos), 64'd100);
        check("pre_reset_vpos", 64'(a_vpos), 64'd50);
        reset = 1'b1;
        MCKF  = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset_pos", 64'({a_hpos, a_vpos}), 64'd0);
        check("mid_reset_rgb", 64'({a_red, a_green, a_blue}), 64'd0);
        check("mid_reset_sync", 64'({a_hsync_b, a_vsync_b}), 64'b11);
        reset = 1'b0;
        MCKF  = 1'b0;
        d_hist.delete();
        check_both("mid_released", 1'b0);
        for (int i = 0; i < 8; i++) pulse(16'($urandom()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
